key_debounce_multi: RTL

Parametrised multi-channel push-button conditioner. It replaces the single-key anti-shake block used on the board top level. Each channel does the following:
- synchronises its raw key input;
- debounces it against a shared sample tick;
- provides a clean level, one-cycle press/release pulses, a per-key toggle latch and a long-press pulse.

It sits between the board pins and the CPU control/step logic.

---
 rtl/key_debounce_multi.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/key_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce_multi
// Description : Multi-channel push-button conditioner. Each channel has a
//               2-flop synchroniser, polarity normalisation, tick-sampled
//               debounce, press/release pulses, a toggle latch and a
//               long-press pulse. All channels share one sample tick.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_multi #(
    parameter int N_KEYS       = 4,
    parameter int TICK_CYCLES  = 1000000,
    parameter int STABLE_TICKS = 4,
    parameter int LONG_TICKS   = 100,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_toggle,
    output logic [N_KEYS-1:0] key_long,
    output logic              tick
);

    localparam int c_TICK_W = $clog2(TICK_CYCLES);
    localparam int c_STAB_W = $clog2(STABLE_TICKS + 1);
    localparam int c_HOLD_W = $clog2(LONG_TICKS + 1);

    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_CYCLES - 1);
    localparam logic [c_STAB_W-1:0] c_STABLE    = c_STAB_W'(STABLE_TICKS);
    localparam logic [c_HOLD_W-1:0] c_LONG      = c_HOLD_W'(LONG_TICKS);
    // Raw pin level that means "not pressed"
    localparam logic                c_RELEASED  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic [c_TICK_W-1:0] r_tick_cnt;
    logic                w_tick;
    logic [N_KEYS-1:0]   r_sync1;
    logic [N_KEYS-1:0]   r_sync2;
    logic [N_KEYS-1:0]   w_pressed;

    assign w_tick = (r_tick_cnt == c_TICK_LAST);
    assign tick   = w_tick;

    // Free-running sample-tick counter, period TICK_CYCLES
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + c_TICK_W'(1);
        end
    end

    // Two-flop synchroniser; resets to the released pin level so no press
    // is seen when reset drops
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= {N_KEYS{c_RELEASED}};
            r_sync2 <= {N_KEYS{c_RELEASED}};
        end else begin
            r_sync1 <= key_in;
            r_sync2 <= r_sync1;
        end
    end

    // Normalise polarity: 1 = pressed
    assign w_pressed = r_sync2 ^ {N_KEYS{c_RELEASED}};

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        logic [c_STAB_W-1:0] r_stab;
        logic [c_STAB_W-1:0] w_stab_inc;
        logic                r_level;
        logic                r_level_d;
        logic                r_press;
        logic                r_release;
        logic                r_toggle;
        logic [c_HOLD_W-1:0] r_hold;
        logic                w_sat;
        logic                r_sat_d;
        logic                r_long;

        assign w_stab_inc = r_stab + c_STAB_W'(1);
        assign w_sat      = (r_hold == c_LONG);

        // Debounce: a differing level must persist STABLE_TICKS ticks in a row
        always_ff @(posedge clk) begin
            if (rst) begin
                r_stab  <= '0;
                r_level <= 1'b0;
            end else if (w_tick) begin
                if (w_pressed[i] == r_level) begin
                    r_stab <= '0;
                end else if (w_stab_inc == c_STABLE) begin
                    r_level <= ~r_level;
                    r_stab  <= '0;
                end else begin
                    r_stab <= w_stab_inc;
                end
            end
        end

        // Registered edge detect on the debounced level, plus toggle latch
        always_ff @(posedge clk) begin
            if (rst) begin
                r_level_d <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_toggle  <= 1'b0;
            end else begin
                r_level_d <= r_level;
                r_press   <= r_level & ~r_level_d;
                r_release <= ~r_level & r_level_d;
                if (r_level & ~r_level_d) begin
                    r_toggle <= ~r_toggle;
                end
            end
        end

        // Hold counter saturates at LONG_TICKS; pulse once on reaching it
        always_ff @(posedge clk) begin
            if (rst) begin
                r_hold  <= '0;
                r_sat_d <= 1'b0;
                r_long  <= 1'b0;
            end else begin
                if (!r_level) begin
                    r_hold <= '0;
                end else if (w_tick && !w_sat) begin
                    r_hold <= r_hold + c_HOLD_W'(1);
                end
                r_sat_d <= w_sat;
                r_long  <= w_sat & ~r_sat_d;
            end
        end

        assign key_level[i]   = r_level;
        assign key_press[i]   = r_press;
        assign key_release[i] = r_release;
        assign key_toggle[i]  = r_toggle;
        assign key_long[i]    = r_long;
    end

endmodule
`default_nettype wire
